// File: rtl/data_mem_resp.sv
// -----------------------------------------------------------------------------
// data_mem_resp
// Wait-stated data-memory responder for the core's load/store path.
// Accepts one word request at a time over a req/ack handshake. After
// WAIT_CYCLES wait cycles it performs the read or write on an internal
// word-addressed RAM, then strobes ack for one cycle. Addresses outside the
// RAM are flagged with err and leave memory untouched.
//
// Ports:
//   clock   in   system clock, rising edge
//   reset   in   asynchronous, active-low reset
//   req     in   request valid; sampled only in IDLE
//   we      in   1 = write, 0 = read; sampled with req
//   addr    in   32-bit word address
//   w_data  in   write data; sampled with req
//   r_data  out  read data; valid with ack on a read, held afterwards
//   ack     out  one-cycle completion strobe
//   err     out  out-of-range flag; valid with ack
//   busy    out  high whenever the responder is not IDLE
// -----------------------------------------------------------------------------
module data_mem_resp #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  we,
  input  logic [31:0]           addr,
  input  logic [DATA_WIDTH-1:0] w_data,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  ack,
  output logic                  err,
  output logic                  busy
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                  state;
  logic [3:0]              count;
  logic [31:0]             lat_addr;
  logic                    lat_we;
  logic [DATA_WIDTH-1:0]   lat_wdata;

  logic [DATA_WIDTH-1:0]   ram [0:DEPTH-1];

  // Access-side view of the request. The only access that happens while
  // still in IDLE is the zero-wait case, which must use the live inputs
  // because nothing has been latched yet; every other access uses the
  // values captured at acceptance.
  logic [31:0]             acc_addr;
  logic                    acc_we;
  logic [DATA_WIDTH-1:0]   acc_wdata;
  logic                    acc_now;
  logic                    acc_in_range;
  logic [ADDR_WIDTH-1:0]   acc_idx;
  logic                    ram_we;

  // NOTE: every signal driven here gets a value on every path, so no latch
  // can be inferred.
  always_comb begin
    acc_addr  = lat_addr;
    acc_we    = lat_we;
    acc_wdata = lat_wdata;
    acc_now   = 1'b0;
    if (state == ST_IDLE) begin
      acc_addr  = addr;
      acc_we    = we;
      acc_wdata = w_data;
      acc_now   = req && (WAIT_CYCLES == 0);
    end else if (state == ST_WAIT) begin
      acc_now   = (count == 4'd1);
    end
  end

  assign acc_in_range = (acc_addr[31:ADDR_WIDTH] == '0);
  assign acc_idx      = acc_addr[ADDR_WIDTH-1:0];
  // Gated with reset so that a request held during reset can never write
  // through the zero-wait path.
  assign ram_we       = reset && acc_now && acc_we && acc_in_range;

  // NOTE: the RAM has no reset; its contents survive reset and it maps onto
  // plain memory macros only because no reset term touches it.
  always_ff @(posedge clock) begin
    if (ram_we) begin
      ram[acc_idx] <= acc_wdata;
    end
  end

  // Control FSM with registered outputs.
  // NOTE: all state here is updated with non-blocking assignments so every
  // register sees pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      count     <= 4'd0;
      lat_addr  <= '0;
      lat_we    <= 1'b0;
      lat_wdata <= '0;
      r_data    <= '0;
      ack       <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            lat_addr  <= addr;
            lat_we    <= we;
            lat_wdata <= w_data;
            busy      <= 1'b1;
            if (WAIT_CYCLES == 0) begin
              state <= ST_RESP;
              ack   <= 1'b1;
            end else begin
              state <= ST_WAIT;
              count <= 4'(WAIT_CYCLES);
            end
          end
        end

        ST_WAIT: begin
          count <= count - 4'd1;
          if (count == 4'd1) begin
            state <= ST_RESP;
            ack   <= 1'b1;
          end
        end

        ST_RESP: begin
          state <= ST_IDLE;
          ack   <= 1'b0;
          err   <= 1'b0;
          busy  <= 1'b0;
        end

        default: begin
          state <= ST_IDLE;
          ack   <= 1'b0;
          err   <= 1'b0;
          busy  <= 1'b0;
        end
      endcase

      // Result side of the access edge; the RAM write itself is above.
      if (acc_now) begin
        err <= !acc_in_range;
        if (!acc_in_range) begin
          r_data <= '0;
        end else if (!acc_we) begin
          r_data <= ram[acc_idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_resp.sv
// -----------------------------------------------------------------------------
// tb_data_mem_resp
// Drives two responders sharing clock and reset: index 0 with two wait
// cycles, index 1 with zero wait cycles. A reference memory per instance
// predicts r_data, err and ack latency for each transaction.
// -----------------------------------------------------------------------------
module tb_data_mem_resp;

  localparam int AW = 8;
  localparam int DW = 32;

  logic clock;
  logic reset;

  logic          req_v   [2];
  logic          we_v    [2];
  logic [31:0]   addr_v  [2];
  logic [DW-1:0] wd_v    [2];
  logic [DW-1:0] rd_v    [2];
  logic          ack_v   [2];
  logic          err_v   [2];
  logic          busy_v  [2];

  int errors = 0;
  int checks = 0;

  // Reference state: contents, which words are known, last read result.
  logic [DW-1:0] mem_model [2][256];
  bit            written   [2][256];
  logic [DW-1:0] last_rd   [2];

  data_mem_resp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_CYCLES(2)) dut_w2 (
    .clock (clock),     .reset (reset),
    .req   (req_v[0]),  .we    (we_v[0]),
    .addr  (addr_v[0]), .w_data(wd_v[0]),
    .r_data(rd_v[0]),   .ack   (ack_v[0]),
    .err   (err_v[0]),  .busy  (busy_v[0])
  );

  data_mem_resp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_CYCLES(0)) dut_w0 (
    .clock (clock),     .reset (reset),
    .req   (req_v[1]),  .we    (we_v[1]),
    .addr  (addr_v[1]), .w_data(wd_v[1]),
    .r_data(rd_v[1]),   .ack   (ack_v[1]),
    .err   (err_v[1]),  .busy  (busy_v[1])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // One full transaction on instance s; inputs are scrambled right after
  // acceptance so any use of live inputs past that edge shows up.
  task automatic do_txn(input int s, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input string tag);
    int            lat;
    int            wc;
    logic [31:0]   exp_rd;
    logic          exp_err;
    wc = (s == 0) ? 2 : 0;
    if (a < 32'd256) begin
      exp_err = 1'b0;
      if (w) begin
        mem_model[s][a[7:0]] = d;
        written[s][a[7:0]]   = 1'b1;
        exp_rd = last_rd[s];
      end else begin
        exp_rd = mem_model[s][a[7:0]];
      end
    end else begin
      exp_err = 1'b1;
      exp_rd  = 32'd0;
    end
    last_rd[s] = exp_rd;

    @(negedge clock);
    req_v[s] = 1'b1; we_v[s] = w; addr_v[s] = a; wd_v[s] = d;
    @(posedge clock);
    #1;
    req_v[s] = 1'b0; we_v[s] = ~w; addr_v[s] = 32'hFFFF_FFFF; wd_v[s] = 32'hFFFF_FFFF;
    lat = 0;
    @(negedge clock);
    while (!ack_v[s] && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    check({tag, "_lat"},   32'(lat),   32'(wc));
    check({tag, "_err"},   {31'd0, err_v[s]},  {31'd0, exp_err});
    check({tag, "_rdata"}, rd_v[s],    exp_rd);
    check({tag, "_busy"},  {31'd0, busy_v[s]}, 32'd1);
    @(negedge clock);
    check({tag, "_ackw"},  {31'd0, ack_v[s]},  32'd0);
    check({tag, "_idle"},  {31'd0, busy_v[s]}, 32'd0);
    check({tag, "_errcl"}, {31'd0, err_v[s]},  32'd0);
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      req_v[s] = 1'b0; we_v[s] = 1'b0; addr_v[s] = '0; wd_v[s] = '0;
      last_rd[s] = '0;
      for (int i = 0; i < 256; i++) begin
        mem_model[s][i] = '0;
        written[s][i]   = 1'b0;
      end
    end

    // Reset held with requests pending: outputs stay quiet.
    reset = 1'b0;
    req_v[0] = 1'b1; we_v[0] = 1'b1; addr_v[0] = 32'h7; wd_v[0] = 32'h1111_1111;
    req_v[1] = 1'b1; we_v[1] = 1'b1; addr_v[1] = 32'h7; wd_v[1] = 32'h2222_2222;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      for (int s = 0; s < 2; s++) begin
        check("rst_ack",   {31'd0, ack_v[s]},  32'd0);
        check("rst_busy",  {31'd0, busy_v[s]}, 32'd0);
        check("rst_err",   {31'd0, err_v[s]},  32'd0);
        check("rst_rdata", rd_v[s],            32'd0);
      end
    end
    req_v[0] = 1'b0; req_v[1] = 1'b0;
    reset = 1'b1;
    repeat (2) begin
      @(negedge clock);
      check("post_rst_busy0", {31'd0, busy_v[0]}, 32'd0);
      check("post_rst_busy1", {31'd0, busy_v[1]}, 32'd0);
    end

    // Directed: write then read, out of range, no aliasing.
    do_txn(0, 1'b1, 32'h05,  32'hDEAD_BEEF, "wr05");
    do_txn(0, 1'b0, 32'h05,  32'h0,         "rd05");
    do_txn(0, 1'b0, 32'h100, 32'h0,         "rd100");
    do_txn(0, 1'b1, 32'h105, 32'h1234_5678, "wr105");
    do_txn(0, 1'b0, 32'h05,  32'h0,         "rd05b");
    do_txn(0, 1'b1, 32'hFF,  32'hA5A5_0001, "wrFF");
    do_txn(0, 1'b0, 32'hFF,  32'h0,         "rdFF");

    // Zero wait: single, then back-to-back with req held high.
    do_txn(1, 1'b1, 32'h03, 32'h600D_F00D, "z_wr03");
    do_txn(1, 1'b0, 32'h03, 32'h0,         "z_rd03");
    do_txn(1, 1'b0, 32'h8000_0003, 32'h0,  "z_rdoor");
    begin
      int  acks;
      bit  prev;
      acks = 0; prev = 1'b0;
      @(negedge clock);
      req_v[1] = 1'b1; we_v[1] = 1'b0; addr_v[1] = 32'h03;
      for (int c = 0; c < 10; c++) begin
        @(negedge clock);
        if (ack_v[1]) begin
          acks++;
          check("z_stream_rd", rd_v[1], 32'h600D_F00D);
          check("z_stream_gap", {31'd0, prev}, 32'd0);
        end
        prev = ack_v[1];
      end
      req_v[1] = 1'b0;
      check("z_stream_cnt", 32'(acks), 32'd5);
      last_rd[1] = 32'h600D_F00D;
      @(negedge clock);
      check("z_stream_idle", {31'd0, busy_v[1]}, 32'd0);
    end

    // Reset during WAIT abandons a pending write.
    do_txn(0, 1'b1, 32'h10, 32'h0BAD_C0DE, "wr10");
    @(negedge clock);
    req_v[0] = 1'b1; we_v[0] = 1'b1; addr_v[0] = 32'h10; wd_v[0] = 32'hCAFE_F00D;
    @(posedge clock);
    #1 req_v[0] = 1'b0;
    #1 reset = 1'b0;
    #1;
    check("rstw_busy", {31'd0, busy_v[0]}, 32'd0);
    #1 reset = 1'b1;
    last_rd[0] = '0;
    last_rd[1] = '0;
    begin
      bit seen;
      seen = 1'b0;
      repeat (5) begin
        @(negedge clock);
        if (ack_v[0]) seen = 1'b1;
      end
      check("rstw_noack", {31'd0, seen}, 32'd0);
    end
    do_txn(0, 1'b0, 32'h10, 32'h0, "rd10");

    // Randomized traffic against the reference memories.
    for (int n = 0; n < 60; n++) begin
      int          s;
      int          kind;
      logic [31:0] a;
      logic        w;
      s    = int'($urandom_range(0, 1));
      kind = int'($urandom_range(0, 99));
      if (kind < 15) begin
        a = $urandom | 32'h100;
        w = 1'($urandom_range(0, 1));
      end else begin
        a = 32'($urandom_range(0, 255));
        w = (kind < 55) ? 1'b1 : 1'b0;
        if (!w && !written[s][a[7:0]]) w = 1'b1;
      end
      do_txn(s, w, a, $urandom, w ? "rnd_wr" : "rnd_rd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_mem_resp.md
Name: data_mem_resp

Overview:
Wait-stated data-memory responder: the slave end of the core's load/store data path, replacing the zero-latency combinational data memory. Accepts one word request at a time over a req/ack handshake. Performs the read or write on an internal word-addressed RAM after a programmable number of wait cycles. Flags out-of-range addresses and leaves memory untouched on those requests.

Parameters:
ADDR_WIDTH, 8, word-address bits decoded; depth = 2**ADDR_WIDTH words
DATA_WIDTH, 32, word width
WAIT_CYCLES, 2, wait cycles between acceptance and access (0..15)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
req  in  1  request valid; sampled only in IDLE
we  in  1  1 = write, 0 = read; sampled with req
addr  in  32  word address from the core's ALU result
w_data  in  DATA_WIDTH  write data; sampled with req
r_data  out  DATA_WIDTH  read data; valid while ack=1 on a read, held afterwards
ack  out  1  one-cycle completion strobe
err  out  1  out-of-range flag; valid with ack
busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset: clock is rising edge; reset is asynchronous, active-low. Reset forces state=IDLE, counter=0, ack=0, err=0, busy=0, r_data=0. RAM contents are not reset.
- Reset mid-transaction: the transaction is abandoned. A pending write is not performed and no ack is issued.
- States: IDLE, WAIT, RESP.
- IDLE:
  - On an edge with req=1, latch addr, we and w_data.
  - If WAIT_CYCLES=0, perform the access at that same edge and go to RESP.
  - Otherwise load counter=WAIT_CYCLES and go to WAIT.
  - On an edge with req=0, stay in IDLE.
- WAIT: each edge decrements the counter. At the edge where counter=1, perform the access and go to RESP.
- RESP:
  - ack=1 for exactly one cycle.
  - Next edge returns to IDLE unconditionally.
  - req is ignored in RESP.
- Latency: with req sampled at edge E, ack rises at edge E+WAIT_CYCLES and falls at E+WAIT_CYCLES+1. The earliest next acceptance is edge E+WAIT_CYCLES+2, so throughput is one transaction per WAIT_CYCLES+2 cycles.
- Requester rule: the requester must drop req in the ack cycle. req still high on the edge after ack is treated as a new request.
- Inputs after acceptance: changes to addr, we or w_data are ignored; the latched values are used.
- Range check: in-range means addr[31:ADDR_WIDTH]==0. The RAM index is addr[ADDR_WIDTH-1:0].
- Access edge, in range:
  - Write: RAM[index] <= latched w_data; r_data unchanged.
  - Read: r_data <= RAM[index].
  - err=0.
- Access edge, out of range: no RAM write, r_data <= 0, err=1. ack is still issued, so the requester never hangs.
- err: valid only while ack=1; cleared on leaving RESP.
- r_data: holds its value between reads; writes do not change it.
- Read-after-write to the same address in back-to-back transactions returns the newly written data. There is no bypass requirement beyond that, since only one transaction is outstanding.
- Address wrap: none. Addresses at or above 2**ADDR_WIDTH are errors, not aliases.
- busy: 1 in WAIT and RESP, 0 in IDLE.

Test Plan:
- Reset: hold reset=0 for 3 cycles with req=1 -> ack=0, busy=0, r_data=0, err=0 throughout; no transaction after release until req is sampled in IDLE.
- Write then read, WAIT_CYCLES=2: write addr=0x05, data=0xDEADBEEF at edge E -> ack at E+2 with err=0. Then read addr=0x05 -> r_data=0xDEADBEEF with ack exactly 2 edges after its acceptance; ack width 1 cycle.
- Out of range: read addr=0x100 (ADDR_WIDTH=8) -> ack with err=1, r_data=0. Write 0x12345678 to 0x105, then read 0x05 -> still 0xDEADBEEF.
- WAIT_CYCLES=0: req at edge E -> ack rises at E. With req held high continuously, transactions complete every 2 cycles.
- Input stability: change addr and w_data to 0xFFFFFFFF during WAIT -> originally latched address and data are used.
- Reset during WAIT: write 0xCAFEF00D to 0x10, pulse reset low in the first WAIT cycle -> no ack; a later read of 0x10 returns the prior value, not 0xCAFEF00D.
